// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time, byte-lane RAM access, buffered response.
// Optional DMEM_MMIO_EN adds a memory-mapped display register (disp_data) at 0xFFFF_FF00.
module dmem_responder #(
   parameter int DEPTH       = 1024,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [1:0]  o_dbg_state
`ifdef DMEM_MMIO_EN
   ,
   output logic [31:0] disp_data
`endif
);

   localparam int         AW       = $clog2(DEPTH);
   localparam logic [3:0] LP_WLAST = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

   // Both handshakes: a transfer happens on a posedge where valid && ready are both high.
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

   state_t      r_state, w_next;
   logic [3:0]  r_cnt, w_cnt_next;
   logic        r_write;
   logic [2:0]  r_funct3;
   logic [31:0] r_addr, r_wdata;
   logic [31:0] r_rdata;
   logic        r_err;
   logic [31:0] r_mem [DEPTH];

   logic        w_accept, w_access;
   logic        w_sel_write;
   logic [2:0]  w_sel_funct3;
   logic [31:0] w_sel_addr, w_sel_wdata;
   logic [AW-1:0] w_idx;
   logic [1:0]  w_lane;
   logic        w_in_range, w_f3_ok, w_align_ok, w_err;
   logic [3:0]  w_be;
   logic [31:0] w_lane_data, w_word, w_shifted, w_load;
   logic [15:0] w_half;
   logic [7:0]  w_byte;
`ifdef DMEM_MMIO_EN
   logic        w_is_mmio;
   logic [31:0] r_disp;
`endif

   assign req_ready   = (r_state == S_IDLE) && !rst;
   assign w_accept    = req_valid && req_ready;
   assign rsp_valid   = (r_state == S_RESP);
   assign rsp_rdata   = r_rdata;
   assign rsp_err     = r_err;
   assign o_dbg_state = r_state;

   // With no wait states the access uses the live request on the accept edge.
   assign w_sel_write  = (r_state == S_IDLE) ? req_write  : r_write;
   assign w_sel_funct3 = (r_state == S_IDLE) ? req_funct3 : r_funct3;
   assign w_sel_addr   = (r_state == S_IDLE) ? req_addr   : r_addr;
   assign w_sel_wdata  = (r_state == S_IDLE) ? req_wdata  : r_wdata;
   assign w_idx        = w_sel_addr[AW+1:2];
   assign w_lane       = w_sel_addr[1:0];

   always_comb begin
      w_next     = r_state;
      w_cnt_next = r_cnt;
      w_access   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (WAIT_CYCLES == 0) begin
                  w_next   = S_RESP;
                  w_access = 1'b1;
               end else begin
                  w_next     = S_WAIT;
                  w_cnt_next = 4'd0;
               end
            end
         end
         S_WAIT: begin
            if (r_cnt == LP_WLAST) begin
               w_next   = S_RESP;
               w_access = 1'b1;
            end else begin
               w_cnt_next = r_cnt + 4'd1;
            end
         end
         S_RESP: begin
            if (rsp_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_in_range = ((w_sel_addr >> (AW + 2)) == 32'd0);
      if (w_sel_write) w_f3_ok = (w_sel_funct3 <= 3'd2);
      else             w_f3_ok = !((w_sel_funct3 == 3'd3) || (w_sel_funct3 == 3'd6) ||
                                   (w_sel_funct3 == 3'd7));
      case (w_sel_funct3[1:0])
         2'b01:   w_align_ok = !w_sel_addr[0];
         2'b10:   w_align_ok = (w_sel_addr[1:0] == 2'b00);
         default: w_align_ok = 1'b1;
      endcase
`ifdef DMEM_MMIO_EN
      w_is_mmio = (w_sel_addr == 32'hFFFF_FF00);
      w_err     = w_is_mmio ? (w_sel_funct3 != 3'd2) : !(w_in_range && w_f3_ok && w_align_ok);
`else
      w_err     = !(w_in_range && w_f3_ok && w_align_ok);
`endif
   end

   // Store data is replicated across lanes; the byte enables pick which lanes land.
   always_comb begin
      w_be        = 4'b0000;
      w_lane_data = w_sel_wdata;
      case (w_sel_funct3[1:0])
         2'b00: begin
            w_be        = 4'b0001 << w_lane;
            w_lane_data = {4{w_sel_wdata[7:0]}};
         end
         2'b01: begin
            w_be        = w_lane[1] ? 4'b1100 : 4'b0011;
            w_lane_data = {2{w_sel_wdata[15:0]}};
         end
         default: w_be = 4'b1111;
      endcase
   end

   always_comb begin
      w_word    = r_mem[w_idx];
      w_shifted = w_word >> {w_lane, 3'b000};
      w_byte    = w_shifted[7:0];
      w_half    = w_lane[1] ? w_word[31:16] : w_word[15:0];
      case (w_sel_funct3)
         3'd0:    w_load = {{24{w_byte[7]}}, w_byte};
         3'd1:    w_load = {{16{w_half[15]}}, w_half};
         3'd2:    w_load = w_word;
         3'd4:    w_load = {24'd0, w_byte};
         3'd5:    w_load = {16'd0, w_half};
         default: w_load = 32'd0;
      endcase
`ifdef DMEM_MMIO_EN
      if (w_is_mmio) w_load = r_disp;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= 4'd0;
         r_rdata  <= 32'd0;
         r_err    <= 1'b0;
         r_write  <= 1'b0;
         r_funct3 <= 3'd0;
         r_addr   <= 32'd0;
         r_wdata  <= 32'd0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_next;
         if (w_accept) begin
            r_write  <= req_write;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
         end
         if (w_access) begin
            r_err   <= w_err;
            r_rdata <= (w_err || w_sel_write) ? 32'd0 : w_load;
         end
      end
   end

   // RAM has no reset; a reset on the access edge suppresses the commit.
   always_ff @(posedge clk) begin
      if (!rst && w_access && w_sel_write && !w_err
`ifdef DMEM_MMIO_EN
          && !w_is_mmio
`endif
         ) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) r_mem[w_idx][b*8 +: 8] <= w_lane_data[b*8 +: 8];
         end
      end
   end

`ifdef DMEM_MMIO_EN
   always_ff @(posedge clk) begin
      if (rst) r_disp <= 32'd0;
      else if (w_access && w_sel_write && w_is_mmio && !w_err) r_disp <= w_sel_wdata;
   end
   assign disp_data = r_disp;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (DEPTH=1024, WAIT_CYCLES=1): vector table plus
// hand sequences for back-pressure, reset during a wait state and optional MMIO.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [2:0]  req_funct3 = 3'd0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [1:0]  o_dbg_state;
`ifdef DMEM_MMIO_EN
   logic [31:0] disp_data;
`endif

   int checks   = 0;
   int failures = 0;
   logic [32:0] exp_q[$];

   dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(1)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .o_dbg_state(o_dbg_state)
`ifdef DMEM_MMIO_EN
      , .disp_data(disp_data)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic add(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] er, input logic ee);
      vec_t v;
      v.wr = wr; v.f3 = f3; v.addr = a; v.wdata = wd; v.exp_rdata = er; v.exp_err = ee;
      vecs.push_back(v);
   endtask

   // Issue one request and collect its response; lat counts cycles from accept to rsp_valid.
   task automatic xact(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er,
                       output int lat);
      int n;
      rd = 32'd0; er = 1'b0; lat = 0; n = 0;
      @(negedge clk);
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         chk("req_ready_timeout", 32'(req_ready), 32'd1);
         return;
      end
      req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
      @(posedge clk);
      #1 req_valid = 1'b0;
      do begin
         @(negedge clk);
         lat++;
      end while (!rsp_valid && lat < 50);
      if (!rsp_valid) begin
         chk("rsp_valid_timeout", 32'(rsp_valid), 32'd1);
         return;
      end
      rd = rsp_rdata; er = rsp_err;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
   endtask

   initial begin
      logic [31:0] rd, hold_rd;
      logic        er, hold_er;
      logic [32:0] exp;
      int          lat, n;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      chk("rst_req_ready_low", 32'(req_ready), 32'd0);
      chk("rst_state", 32'(o_dbg_state), 32'd0);
      rst = 1'b0;
      #1 chk("post_rst_req_ready", 32'(req_ready), 32'd1);

      add(1, 3'd2, 32'h10,  32'h8765_4321, 32'h0,         0);
      add(0, 3'd2, 32'h10,  32'h0,         32'h8765_4321, 0);
      add(1, 3'd0, 32'h13,  32'h0000_00AA, 32'h0,         0);
      add(0, 3'd2, 32'h10,  32'h0,         32'hAA65_4321, 0);
      add(0, 3'd0, 32'h13,  32'h0,         32'hFFFF_FFAA, 0);
      add(0, 3'd4, 32'h13,  32'h0,         32'h0000_00AA, 0);
      add(0, 3'd1, 32'h12,  32'h0,         32'hFFFF_AA65, 0);
      add(0, 3'd5, 32'h10,  32'h0,         32'h0000_4321, 0);
      add(0, 3'd0, 32'h11,  32'h0,         32'h0000_0043, 0);
      add(1, 3'd2, 32'h20,  32'h1122_3344, 32'h0,         0);
      add(1, 3'd1, 32'h22,  32'h0000_8001, 32'h0,         0);
      add(0, 3'd1, 32'h22,  32'h0,         32'hFFFF_8001, 0);
      add(0, 3'd5, 32'h22,  32'h0,         32'h0000_8001, 0);
      add(0, 3'd2, 32'h20,  32'h0,         32'h8001_3344, 0);
      add(0, 3'd2, 32'h11,  32'h0,         32'h0,         1);
      add(1, 3'd1, 32'h23,  32'hFFFF_FFFF, 32'h0,         1);
      add(0, 3'd2, 32'h1000,32'h0,         32'h0,         1);
      add(0, 3'd3, 32'h10,  32'h0,         32'h0,         1);
      add(0, 3'd2, 32'h20,  32'h0,         32'h8001_3344, 0);
      add(1, 3'd2, 32'h0,   32'h5555_AAAA, 32'h0,         0);
      add(1, 3'd2, 32'h1000,32'hDEAD_BEEF, 32'h0,         1);
      add(1, 3'd4, 32'h10,  32'h0000_0000, 32'h0,         1);
      add(0, 3'd2, 32'h0,   32'h0,         32'h5555_AAAA, 0);
      add(0, 3'd2, 32'h10,  32'h0,         32'hAA65_4321, 0);
      add(1, 3'd2, 32'hFFC, 32'h0BAD_F00D, 32'h0,         0);
      add(0, 3'd2, 32'hFFC, 32'h0,         32'h0BAD_F00D, 0);
      add(1, 3'd2, 32'h30,  32'h0,         32'h0,         0);
`ifndef DMEM_MMIO_EN
      add(0, 3'd2, 32'hFFFF_FF00, 32'h0,   32'h0,         1);
`endif

      foreach (vecs[i]) begin
         exp_q.push_back({vecs[i].exp_err, vecs[i].exp_rdata});
         xact(vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, er, lat);
         exp = exp_q.pop_front();
         chk($sformatf("vec%0d_rdata", i), rd, exp[31:0]);
         chk($sformatf("vec%0d_err", i), 32'(er), 32'(exp[32]));
         chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
      end

      // Back-pressure: response held for 5 cycles
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd2; req_addr = 32'h20;
      @(posedge clk);
      #1 req_valid = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rsp_valid && n < 50);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      hold_rd = rsp_rdata; hold_er = rsp_err;
      chk("bp_rdata", hold_rd, 32'h8001_3344);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk($sformatf("bp_hold%0d_valid", k), 32'(rsp_valid), 32'd1);
         chk($sformatf("bp_hold%0d_rdata", k), rsp_rdata, 32'h8001_3344);
         chk($sformatf("bp_hold%0d_err", k), 32'(rsp_err), 32'(hold_er));
         chk($sformatf("bp_hold%0d_req_ready", k), 32'(req_ready), 32'd0);
         chk($sformatf("bp_hold%0d_state", k), 32'(o_dbg_state), 32'd2);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      @(negedge clk);
      chk("bp_release_req_ready", 32'(req_ready), 32'd1);
      chk("bp_release_rsp_valid", 32'(rsp_valid), 32'd0);

      // Reset during the wait state of a store to 0x30 (currently 0)
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd2; req_addr = 32'h30;
      req_wdata = 32'hCAFE_F00D;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("rstwait_state", 32'(o_dbg_state), 32'd1);
      rst = 1'b1;
      #1 chk("rstwait_req_ready_in_rst", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rstwait_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rstwait_req_ready", 32'(req_ready), 32'd1);
      xact(1'b0, 3'd2, 32'h30, 32'h0, rd, er, lat);
      chk("rstwait_lw30_rdata", rd, 32'h0);
      chk("rstwait_lw30_err", 32'(er), 32'd0);

`ifdef DMEM_MMIO_EN
      chk("mmio_disp_reset", disp_data, 32'h0);
      xact(1'b1, 3'd2, 32'hFFFF_FF00, 32'h0000_1234, rd, er, lat);
      chk("mmio_sw_err", 32'(er), 32'd0);
      chk("mmio_disp_data", disp_data, 32'h0000_1234);
      xact(1'b0, 3'd2, 32'hFFFF_FF00, 32'h0, rd, er, lat);
      chk("mmio_lw_rdata", rd, 32'h0000_1234);
      xact(1'b1, 3'd1, 32'hFFFF_FF00, 32'h0000_5678, rd, er, lat);
      chk("mmio_sh_err", 32'(er), 32'd1);
      chk("mmio_sh_disp_unchanged", disp_data, 32'h0000_1234);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
